// File: rtl/otter_uart_tx.sv
`default_nettype none
//==============================================================================
// Module   : otter_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter for the OTTER MCU IO bus.
//            Bus stores to DATA are queued in a TX FIFO and serialised LSB
//            first. STATUS and DIV are readable on IOBUS_IN. INTR pulses for
//            one cycle when the last queued frame has finished.
// Revision : 1.0 - initial release
//==============================================================================
module otter_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        INTR
);

    localparam int          c_AW          = $clog2(FIFO_DEPTH);
    localparam int          c_CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(FIFO_DEPTH);
    localparam logic [31:0] c_ADDR_DATA   = BASE_ADDR;
    localparam logic [31:0] c_ADDR_STATUS = BASE_ADDR + 32'd4;
    localparam logic [31:0] c_ADDR_DIV    = BASE_ADDR + 32'd8;
    localparam logic [15:0] c_MIN_DIV     = 16'd2;

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_START    = 2'd1;
    localparam logic [1:0]  c_ST_DATA     = 2'd2;
    localparam logic [1:0]  c_ST_STOP     = 2'd3;

    // FIFO state
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic [15:0]     r_div;

    // Transmitter state
    logic [1:0]      r_state;
    logic [15:0]     r_bcnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [15:0]     r_div_q;
    logic            r_tx;
    logic            r_intr;

    // Next-state values from the transmitter FSM
    logic [1:0]      w_state_next;
    logic [15:0]     w_bcnt_next;
    logic [2:0]      w_bit_next;
    logic [7:0]      w_shift_next;
    logic [15:0]     w_div_q_next;
    logic            w_tx_next;
    logic            w_intr_next;
    logic            w_pop;

    logic            w_push_req;
    logic            w_push_ok;
    logic            w_stat_wr;
    logic            w_div_wr;
    logic            w_empty;
    logic            w_full;
    logic            w_busy;
    logic            w_boundary;
    logic [7:0]      w_head;
    logic [3:0]      w_count_sat;
    logic            w_unused;

    assign w_push_req = IOBUS_WR && (IOBUS_ADDR == c_ADDR_DATA);
    assign w_stat_wr  = IOBUS_WR && (IOBUS_ADDR == c_ADDR_STATUS);
    assign w_div_wr   = IOBUS_WR && (IOBUS_ADDR == c_ADDR_DIV);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_COUNT);
    // A push into a full FIFO still lands if the FSM frees a slot on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_busy     = (r_state != c_ST_IDLE);
    assign w_boundary = (r_bcnt == 16'd0);
    assign w_head     = r_mem[r_rptr];
    assign w_unused   = &{1'b0, IOBUS_OUT[31:16]};

    assign TX   = r_tx;
    assign INTR = r_intr;

    // FIFO storage; contents are don't-care while count says empty, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Baud divisor register; values below 2 cannot time a bit and are clamped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div <= DEFAULT_DIV;
        end else if (w_div_wr) begin
            r_div <= (IOBUS_OUT[15:0] < c_MIN_DIV) ? c_MIN_DIV : IOBUS_OUT[15:0];
        end
    end

    // Transmitter state register; TX returns high the instant reset asserts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_ST_IDLE;
            r_bcnt  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_div_q <= DEFAULT_DIV;
            r_tx    <= 1'b1;
            r_intr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_div_q <= w_div_q_next;
            r_tx    <= w_tx_next;
            r_intr  <= w_intr_next;
        end
    end

    // Frame sequencing: start bit, 8 data bits LSB first, stop bit, with the
    // next queued byte launched straight from the stop boundary.
    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_div_q_next = r_div_q;
        w_tx_next    = r_tx;
        w_intr_next  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_div_q_next = r_div;
                    w_bcnt_next  = r_div - 16'd1;
                    w_tx_next    = 1'b0;
                    w_state_next = c_ST_START;
                end
            end
            c_ST_START: begin
                w_bcnt_next = r_bcnt - 16'd1;
                if (w_boundary) begin
                    w_bcnt_next  = r_div_q - 16'd1;
                    w_tx_next    = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = 3'd0;
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                w_bcnt_next = r_bcnt - 16'd1;
                if (w_boundary) begin
                    w_bcnt_next = r_div_q - 16'd1;
                    if (r_bit == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = c_ST_STOP;
                    end else begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                    end
                end
            end
            c_ST_STOP: begin
                w_bcnt_next = r_bcnt - 16'd1;
                if (w_boundary) begin
                    if (!w_empty) begin
                        // Divisor is re-latched here so DIV writes apply per frame.
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_div_q_next = r_div;
                        w_bcnt_next  = r_div - 16'd1;
                        w_tx_next    = 1'b0;
                        w_state_next = c_ST_START;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_intr_next  = 1'b1;
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Occupancy shown in STATUS saturates at 15 for deep FIFOs.
    always_comb begin
        w_count_sat = 4'(r_count);
        if (32'(r_count) > 32'd15) begin
            w_count_sat = 4'hF;
        end
    end

    // Read mux decodes the live bus address; reads have no side effects.
    always_comb begin
        IOBUS_IN = 32'd0;
        if (IOBUS_ADDR == c_ADDR_STATUS) begin
            IOBUS_IN = {24'd0, w_count_sat, r_ovf, w_empty, w_full, w_busy};
        end else if (IOBUS_ADDR == c_ADDR_DIV) begin
            IOBUS_IN = {16'd0, r_div};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_uart_tx.sv
`default_nettype none
//==============================================================================
// Module   : tb_otter_uart_tx
// Brief    : Self-checking bench for otter_uart_tx. Expected serial waveforms
//            are built from byte/divisor lists using the 8N1 frame rule.
// Revision : 1.0 - initial release
//==============================================================================
module tb_otter_uart_tx;

    localparam logic [31:0] c_BASE   = 32'h1100_0100;
    localparam logic [31:0] c_A_DATA = c_BASE;
    localparam logic [31:0] c_A_STAT = c_BASE + 32'd4;
    localparam logic [31:0] c_A_DIV  = c_BASE + 32'd8;
    localparam logic [31:0] c_A_NONE = c_BASE + 32'd12;

    logic        CLK;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        INTR;

    int n_total;
    int n_bad;

    // Expected frames: one byte and the divisor it should be sent with.
    bit [7:0] q_bytes[$];
    int       q_divs[$];

    otter_uart_tx dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #600000;
        $display("FAIL watchdog: got=timeout need=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h need=0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits just after a falling edge; the store is taken on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = c_A_NONE;
        IOBUS_OUT  = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
        IOBUS_ADDR = c_A_NONE;
    endtask

    // Line level in bit slot 0..9 of an 8N1 frame.
    function automatic logic exp_line(input bit [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Wait for the start bit, then compare every cycle against the frame list,
    // and finally expect a single-cycle INTR right after the last stop bit.
    task automatic watch_frames();
        int lat;
        int found;
        int wrong;
        int intr_hits;
        lat = 0;
        found = 0;
        for (int t = 1; t <= 64; t++) begin
            @(negedge CLK);
            if (TX === 1'b0) begin
                lat = t;
                found = 1;
                break;
            end
        end
        chk("start_seen", found, 1);
        if (found == 0) return;
        chk("start_latency", lat, 2);
        wrong = 0;
        intr_hits = 0;
        foreach (q_bytes[f]) begin
            for (int s = 0; s < 10 * q_divs[f]; s++) begin
                if (!(f == 0 && s == 0)) @(negedge CLK);
                if (TX !== exp_line(q_bytes[f], s / q_divs[f])) wrong++;
                if (INTR !== 1'b0) intr_hits++;
            end
        end
        chk("tx_wave_errs", wrong, 0);
        chk("intr_in_frames", intr_hits, 0);
        @(negedge CLK);
        chk("intr_pulse", 32'(INTR), 1);
        chk("tx_idle_after", 32'(TX), 1);
        @(negedge CLK);
        chk("intr_width", 32'(INTR), 0);
    endtask

    task automatic push_queue();
        foreach (q_bytes[i]) bus_write(c_A_DATA, {24'd0, q_bytes[i]});
    endtask

    logic [31:0] rd;
    int          raw_div;
    int          eff_div;
    int          nbytes;
    int          errs;
    bit [7:0]    burst[13];

    initial begin
        n_total    = 0;
        n_bad      = 0;
        RST_N      = 1'b0;
        IOBUS_ADDR = c_A_NONE;
        IOBUS_OUT  = 32'd0;
        IOBUS_WR   = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset values
        chk("rst_tx", 32'(TX), 1);
        chk("rst_intr", 32'(INTR), 0);
        bus_read(c_A_STAT, rd); chk("rst_status", rd, 32'h04);
        bus_read(c_A_DIV, rd);  chk("rst_div", rd, 32'd868);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // 0x55 at 4 clocks per bit
        bus_write(c_A_DIV, 32'd4);
        q_bytes = '{8'h55};
        q_divs  = '{4};
        fork
            watch_frames();
            push_queue();
        join
        bus_read(c_A_STAT, rd); chk("idle_status", rd, 32'h04);

        // Two back-to-back frames at 2 clocks per bit
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd2);
        q_bytes = '{8'hA1, 8'h3C};
        q_divs  = '{2, 2};
        fork
            watch_frames();
            push_queue();
        join

        // DIV change during a frame applies from the next frame only
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd4);
        q_bytes = '{8'hC5, 8'h2E};
        q_divs  = '{4, 8};
        fork
            watch_frames();
            begin
                push_queue();
                repeat (5) @(negedge CLK);
                bus_write(c_A_DIV, 32'd8);
            end
        join
        bus_read(c_A_DIV, rd); chk("div_mid_frame", rd, 32'd8);

        // Degenerate divisors clamp to 2
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd0);
        bus_read(c_A_DIV, rd); chk("div_zero", rd, 32'd2);
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd1);
        bus_read(c_A_DIV, rd); chk("div_one", rd, 32'd2);

        // Randomised byte bursts and divisors
        for (int it = 0; it < 6; it++) begin
            @(negedge CLK);
            raw_div = int'($urandom_range(0, 6));
            eff_div = (raw_div < 2) ? 2 : raw_div;
            bus_write(c_A_DIV, 32'(raw_div));
            bus_read(c_A_DIV, rd); chk("div_rand", rd, 32'(eff_div));
            nbytes = int'($urandom_range(1, 4));
            q_bytes.delete();
            q_divs.delete();
            for (int i = 0; i < nbytes; i++) begin
                q_bytes.push_back(8'($urandom));
                q_divs.push_back(eff_div);
            end
            @(negedge CLK);
            fork
                watch_frames();
                push_queue();
            join
        end

        // Overflow: 12 stores in 12 cycles at DIV=2. The first byte moves to the
        // shifter one cycle after its store, so bytes 2..9 fill the FIFO and
        // 10..12 are dropped. Byte 13 is stored on the edge the first stop bit
        // ends, when the FIFO is full but pops, so it must be accepted.
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd2);
        for (int i = 0; i < 13; i++) burst[i] = 8'($urandom);
        q_bytes.delete();
        q_divs.delete();
        for (int i = 0; i < 9; i++) begin
            q_bytes.push_back(burst[i]);
            q_divs.push_back(2);
        end
        q_bytes.push_back(burst[12]);
        q_divs.push_back(2);
        fork
            watch_frames();
            begin
                for (int i = 0; i < 12; i++) bus_write(c_A_DATA, {24'd0, burst[i]});
                repeat (9) @(negedge CLK);
                bus_write(c_A_DATA, {24'd0, burst[12]});
            end
        join
        bus_read(c_A_STAT, rd); chk("ovf_sticky", rd, 32'h0C);
        @(negedge CLK);
        bus_write(c_A_STAT, 32'hFFFF_FFFF);
        bus_read(c_A_STAT, rd); chk("ovf_cleared", rd, 32'h04);

        // Stalled transmitter: 10 stores fill the FIFO and set ovf
        @(negedge CLK);
        bus_write(c_A_DIV, 32'd1000);
        bus_write(c_A_DATA, 32'h00);
        for (int i = 1; i < 10; i++) bus_write(c_A_DATA, 32'($urandom_range(0, 255)));
        bus_read(c_A_STAT, rd); chk("stall_status", rd, 32'h8B);
        @(negedge CLK);
        bus_write(c_A_STAT, 32'd0);
        bus_read(c_A_STAT, rd); chk("stall_ovf_clr", rd, 32'h83);

        // Reset in the middle of data bit 0 (a 0 bit) of the first frame
        repeat (1500) @(negedge CLK);
        chk("mid_data_tx", 32'(TX), 0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_tx", 32'(TX), 1);
        chk("async_rst_intr", 32'(INTR), 0);
        bus_read(c_A_STAT, rd); chk("async_rst_status", rd, 32'h04);
        bus_read(c_A_DIV, rd);  chk("async_rst_div", rd, 32'd868);
        @(negedge CLK);
        RST_N = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || INTR !== 1'b0) errs++;
        end
        chk("post_rst_quiet", errs, 0);
        bus_read(c_A_STAT, rd); chk("post_rst_status", rd, 32'h04);

        // Unmapped addresses read 0 and ignore writes
        bus_read(c_A_NONE, rd);            chk("unmapped_rd", rd, 32'd0);
        bus_read(c_BASE + 32'd16, rd);     chk("unmapped_rd2", rd, 32'd0);
        bus_read(c_A_DATA, rd);            chk("data_rd_zero", rd, 32'd0);
        @(negedge CLK);
        bus_write(c_A_NONE, 32'hFFFF_FFFF);
        bus_write(c_BASE - 32'd4, 32'h0000_00AA);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || INTR !== 1'b0) errs++;
        end
        chk("unmapped_quiet", errs, 0);
        bus_read(c_A_STAT, rd); chk("unmapped_status", rd, 32'h04);
        bus_read(c_A_DIV, rd);  chk("unmapped_div", rd, 32'd868);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
